// File: rtl/dog_pkg.sv
// Shared types for the toy-dog button/speed front-end.
package dog_pkg;

   typedef logic [1:0] speed_t;

   localparam speed_t SPD_STOP = 2'd0;
   localparam speed_t SPD_SLOW = 2'd1;
   localparam speed_t SPD_MED  = 2'd2;
   localparam speed_t SPD_FAST = 2'd3;

   typedef enum logic [1:0] {
      BTN_IDLE,
      BTN_HELD,
      BTN_LONG
   } btn_state_t;

   // Short-press step; 2-bit wrap gives FAST -> STOP.
   function automatic speed_t speed_step(input speed_t s);
      return s + 2'd1;
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronises the raw active-low button and accepts a level change only
// after it has been stable for DEB_CYCLES cycles.
module debounce_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic level,
   output logic rise_p,
   output logic fall_p
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   btn_s;

   assign btn_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], ~raw_n};
      cnt_d   = '0;
      level_d = level_q;
      // Any return to the accepted level restarts the stability window.
      if (btn_s != level_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1))
            level_d = btn_s;
         else
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level  = level_q;
   assign rise_p = level_d & ~level_q;
   assign fall_p = ~level_d & level_q;

endmodule

// File: rtl/speed_button_ctrl.sv
// Button front-end: debounced press classification (short/long) and the
// 2-bit speed register driving the clock selector and display.
module speed_button_ctrl
   import dog_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 1_000_000,
   parameter int LONG_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       but_n,
   output logic [1:0] speed,
   output logic       spd_chg_p,
   output logic       act_rst_p,
   output logic       pressed
);

   localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

   btn_state_t    state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   speed_t        speed_q, speed_d;
   logic          spd_chg_q, spd_chg_d;
   logic          act_rst;
   logic          rise_p, fall_p;

   debounce_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
   ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_n  (but_n),
      .level  (pressed),
      .rise_p (rise_p),
      .fall_p (fall_p)
   );

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      speed_d = speed_q;
      act_rst = 1'b0;
      if (!en) begin
         // Debouncer keeps tracking, so a button held across en rising
         // produces no rise edge and is ignored until released.
         state_d = BTN_IDLE;
         hold_d  = '0;
         speed_d = SPD_STOP;
      end else begin
         case (state_q)
            BTN_IDLE: if (rise_p) begin
               state_d = BTN_HELD;
               hold_d  = '0;
            end
            BTN_HELD: begin
               // Long detection wins over a release landing in the same cycle.
               if (hold_q == HW'(LONG_CYCLES - 1)) begin
                  act_rst = 1'b1;
                  speed_d = SPD_STOP;
                  state_d = fall_p ? BTN_IDLE : BTN_LONG;
               end else if (fall_p) begin
                  state_d = BTN_IDLE;
                  speed_d = speed_step(speed_q);
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            BTN_LONG: if (fall_p) state_d = BTN_IDLE;
            default:  state_d = BTN_IDLE;
         endcase
      end
      spd_chg_d = (speed_d != speed_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BTN_IDLE;
         hold_q    <= '0;
         speed_q   <= SPD_STOP;
         spd_chg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         speed_q   <= speed_d;
         spd_chg_q <= spd_chg_d;
      end
   end

   assign speed     = speed_q;
   assign spd_chg_p = spd_chg_q;
   assign act_rst_p = act_rst;

endmodule

// File: tb/tb_speed_button_ctrl.sv
// Scoreboard bench: press-level model predicts pulse kind, cycle and speed.
module tb_speed_button_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       but_n = 1'b1;
   logic [1:0] speed;
   logic       spd_chg_p, act_rst_p, pressed;

   speed_button_ctrl #(
      .SYNC_STAGES (2),
      .DEB_CYCLES  (4),
      .LONG_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .but_n     (but_n),
      .speed     (speed),
      .spd_chg_p (spd_chg_p),
      .act_rst_p (act_rst_p),
      .pressed   (pressed)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_act;
      logic [1:0] spd;
      int         at;
   } ev_t;

   ev_t q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  spd_m   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest prediction, at its cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("pulse_overlap", int'(spd_chg_p & act_rst_p), 0);
         if (spd_chg_p || act_rst_p) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse", int'(spd_chg_p | act_rst_p), 0);
            end else begin
               ev_t e;
               e = q.pop_front();
               chk("event_kind_act", int'(act_rst_p), int'(e.is_act));
               chk("event_cycle", cyc, e.at);
               if (!e.is_act) chk("event_speed", int'(speed), int'(e.spd));
            end
         end else if (q.size() > 0 && q[0].at < cyc) begin
            chk("missed_event_pulse", int'(spd_chg_p | act_rst_p), 1);
            void'(q.pop_front());
         end
      end
   end

   // Press held h cycles: pressed rises c0+6, falls release+6 (2 sync + 4 deb);
   // long press (h >= 16) fires act_rst 15 cycles after pressed rises.
   task automatic press(input int h, input int gap);
      int c0;
      @(posedge clk); #1;
      c0 = cyc;
      but_n = 1'b0;
      if (h >= 16) begin
         q.push_back('{is_act: 1'b1, spd: 2'd0, at: c0 + 21});
         if (spd_m != 0) q.push_back('{is_act: 1'b0, spd: 2'd0, at: c0 + 22});
         spd_m = 0;
      end else begin
         spd_m = (spd_m + 1) % 4;
         q.push_back('{is_act: 1'b0, spd: 2'(spd_m), at: c0 + h + 6});
      end
      repeat (h) @(posedge clk);
      #1 but_n = 1'b1;
      repeat (gap) @(posedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ce;
      #12;
      chk("reset_speed",   int'(speed), 0);
      chk("reset_spd_chg", int'(spd_chg_p), 0);
      chk("reset_act_rst", int'(act_rst_p), 0);
      chk("reset_pressed", int'(pressed), 0);
      rst_n = 1'b1;
      en    = 1'b1;
      repeat (3) @(posedge clk);

      // Bounce shorter than the debounce window.
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         but_n = ~but_n;
         repeat (2) @(posedge clk);
         #1 chk("bounce_pressed", int'(pressed), 0);
      end
      but_n = 1'b1;
      repeat (10) @(posedge clk);
      chk("bounce_speed", int'(speed), spd_m);

      // Short presses 1,2,3,0.
      for (int i = 0; i < 4; i++) press(8, 10);
      chk("short_wrap_speed", int'(speed), spd_m);

      // Long press from speed 2, then long press at speed 0.
      press(8, 10);
      press(8, 10);
      press(40, 10);
      press(20, 10);

      // Boundary: 15 cycles is short, 16 is long.
      press(15, 10);
      press(16, 10);

      // en drop while held at speed 3.
      press(8, 10); press(8, 10); press(8, 10);
      @(posedge clk); #1 but_n = 1'b0;
      repeat (10) @(posedge clk);
      #1 ce = cyc;
      en = 1'b0;
      if (spd_m != 0) q.push_back('{is_act: 1'b0, spd: 2'd0, at: ce + 1});
      spd_m = 0;
      repeat (5) @(posedge clk);
      #1 en = 1'b1;
      repeat (4) @(posedge clk);
      #1 but_n = 1'b1;
      repeat (12) @(posedge clk);
      chk("en_drop_speed", int'(speed), 0);
      press(8, 10);

      // Randomized press mix.
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) press($urandom_range(16, 30), $urandom_range(8, 14));
         else                            press($urandom_range(5, 15), $urandom_range(8, 14));
      end
      chk("random_speed", int'(speed), spd_m);

      // Async reset in the middle of a press.
      if (spd_m == 0) press(8, 10);
      @(posedge clk); #1 but_n = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      q.delete();
      spd_m = 0;
      #1;
      chk("midrst_speed",   int'(speed), 0);
      chk("midrst_spd_chg", int'(spd_chg_p), 0);
      chk("midrst_act_rst", int'(act_rst_p), 0);
      chk("midrst_pressed", int'(pressed), 0);
      #3 but_n = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      press(8, 10);

      for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      #1 chk("final_speed", int'(speed), spd_m);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
